// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 machine-mode trap/return controller.
package msrv32_pkg;

  typedef enum logic [1:0] {
    STATE_RESET       = 2'b00,
    STATE_OPERATING   = 2'b01,
    STATE_TRAP_TAKEN  = 2'b10,
    STATE_TRAP_RETURN = 2'b11
  } state_e;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_IRQ         = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_IRQ      = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_IRQ        = 4'd11;

  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

endpackage

// File: rtl/msrv32_trap_cause_enc.sv
// Priority encoder from pending exception/interrupt flags to mcause fields.
// Exceptions always outrank interrupts; irq inputs arrive already enable-masked.
module msrv32_trap_cause_enc
  import msrv32_pkg::*;
(
  input  logic       i_misaligned_instr,
  input  logic       i_illegal,
  input  logic       i_ebreak,
  input  logic       i_misaligned_load,
  input  logic       i_misaligned_store,
  input  logic       i_ecall,
  input  logic       i_e_irq,
  input  logic       i_s_irq,
  input  logic       i_t_irq,
  output logic [3:0] o_cause,
  output logic       o_i_or_e,
  output logic       o_misaligned
);

  always_comb begin
    o_cause      = 4'd0;
    o_i_or_e     = 1'b0;
    o_misaligned = 1'b0;
    if (i_misaligned_instr) begin
      o_cause      = CAUSE_MISALIGNED_INSTR;
      o_misaligned = 1'b1;
    end else if (i_illegal) begin
      o_cause = CAUSE_ILLEGAL_INSTR;
    end else if (i_ebreak) begin
      o_cause = CAUSE_BREAKPOINT;
    end else if (i_misaligned_load) begin
      o_cause      = CAUSE_MISALIGNED_LOAD;
      o_misaligned = 1'b1;
    end else if (i_misaligned_store) begin
      o_cause      = CAUSE_MISALIGNED_STORE;
      o_misaligned = 1'b1;
    end else if (i_ecall) begin
      o_cause = CAUSE_ECALL_M;
    end else if (i_e_irq) begin
      o_cause  = CAUSE_M_EXT_IRQ;
      o_i_or_e = 1'b1;
    end else if (i_s_irq) begin
      o_cause  = CAUSE_M_SW_IRQ;
      o_i_or_e = 1'b1;
    end else if (i_t_irq) begin
      o_cause  = CAUSE_M_TIMER_IRQ;
      o_i_or_e = 1'b1;
    end
  end

endmodule

// File: rtl/msrv32_machine_control.sv
// M-mode trap entry/return sequencer for the msrv32 core.
//   STATE_RESET       | boot: fetch from boot vector, flush
//   STATE_OPERATING   | normal execution, traps/mret detected here
//   STATE_TRAP_TAKEN  | one cycle: write mcause/mepc, clear MIE, jump to vector
//   STATE_TRAP_RETURN | one cycle: restore MIE, jump to mepc
module msrv32_machine_control
  import msrv32_pkg::*;
(
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       misaligned_instr_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       e_irq_in,
  input  logic       t_irq_in,
  input  logic       s_irq_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  output logic       trap_taken_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       set_cause_out,
  output logic [3:0] cause_out,
  output logic       i_or_e_out,
  output logic       set_epc_out,
  output logic       misaligned_exception_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out
);

  state_e     r_state, w_state_nxt;
  logic [3:0] r_cause;
  logic       r_i_or_e, r_misaligned;

  logic       w_sys_base, w_ecall, w_ebreak, w_mret;
  logic       w_e_irq, w_s_irq, w_t_irq;
  logic       w_exception, w_interrupt;
  logic [3:0] w_cause;
  logic       w_i_or_e, w_misaligned;

  assign w_sys_base = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == 3'b000)
                      && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign w_ecall  = w_sys_base && (funct7_in == 7'd0)        && (rs2_addr_in == 5'd0);
  assign w_ebreak = w_sys_base && (funct7_in == 7'd0)        && (rs2_addr_in == 5'd1);
  assign w_mret   = w_sys_base && (funct7_in == 7'b0011000)  && (rs2_addr_in == 5'd2);

  assign w_e_irq = mie_in & e_irq_in & meie_in;
  assign w_s_irq = mie_in & s_irq_in & msie_in;
  assign w_t_irq = mie_in & t_irq_in & mtie_in;

  assign w_exception = illegal_instr_in | misaligned_instr_in | misaligned_load_in
                       | misaligned_store_in | w_ecall | w_ebreak;
  assign w_interrupt = w_e_irq | w_s_irq | w_t_irq;

  // Gated by OPERATING so irq levels are ignored during the one-cycle states.
  assign trap_taken_out = (r_state == STATE_OPERATING) & (w_exception | w_interrupt);

  msrv32_trap_cause_enc u_cause_enc (
    .i_misaligned_instr (misaligned_instr_in),
    .i_illegal          (illegal_instr_in),
    .i_ebreak           (w_ebreak),
    .i_misaligned_load  (misaligned_load_in),
    .i_misaligned_store (misaligned_store_in),
    .i_ecall            (w_ecall),
    .i_e_irq            (w_e_irq),
    .i_s_irq            (w_s_irq),
    .i_t_irq            (w_t_irq),
    .o_cause            (w_cause),
    .o_i_or_e           (w_i_or_e),
    .o_misaligned       (w_misaligned)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state      <= STATE_RESET;
      r_cause      <= 4'd0;
      r_i_or_e     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (trap_taken_out) begin
        r_cause      <= w_cause;
        r_i_or_e     <= w_i_or_e;
        r_misaligned <= w_misaligned;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    pc_src_out      = PC_SRC_NEXT;
    flush_out       = 1'b0;
    set_cause_out   = 1'b0;
    set_epc_out     = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (r_state)
      STATE_RESET: begin
        w_state_nxt = STATE_OPERATING;
        pc_src_out  = PC_SRC_BOOT;
        flush_out   = 1'b1;
      end
      STATE_OPERATING: begin
        instret_inc_out = ~trap_taken_out;
        if (trap_taken_out)
          w_state_nxt = STATE_TRAP_TAKEN;
        else if (w_mret)
          w_state_nxt = STATE_TRAP_RETURN;
      end
      STATE_TRAP_TAKEN: begin
        w_state_nxt   = STATE_OPERATING;
        pc_src_out    = PC_SRC_TRAP;
        flush_out     = 1'b1;
        set_cause_out = 1'b1;
        set_epc_out   = 1'b1;
        mie_clear_out = 1'b1;
      end
      STATE_TRAP_RETURN: begin
        w_state_nxt = STATE_OPERATING;
        pc_src_out  = PC_SRC_EPC;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
      end
      default: w_state_nxt = STATE_RESET;
    endcase
  end

  assign cause_out                = r_cause;
  assign i_or_e_out               = r_i_or_e;
  assign misaligned_exception_out = r_misaligned;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed-vector bench for msrv32_machine_control with hand-computed expectations.
module tb_msrv32_machine_control;

  logic       clk, rst;
  logic       illegal, mis_ld, mis_st, mis_in;
  logic [4:0] opc, rs1, rs2, rd;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       e_irq, t_irq, s_irq, mie, meie, mtie, msie;
  logic       trap_taken, flush, set_cause, i_or_e, set_epc, misal, mie_clr, mie_set, instret;
  logic [1:0] pc_src;
  logic [3:0] cause;

  int n_vec = 0;
  int n_err = 0;

  msrv32_machine_control dut (
    .ms_riscv32_mp_clk_in     (clk),
    .ms_riscv32_mp_rst_in     (rst),
    .illegal_instr_in         (illegal),
    .misaligned_load_in       (mis_ld),
    .misaligned_store_in      (mis_st),
    .misaligned_instr_in      (mis_in),
    .opcode_6_to_2_in         (opc),
    .funct3_in                (f3),
    .funct7_in                (f7),
    .rs1_addr_in              (rs1),
    .rs2_addr_in              (rs2),
    .rd_addr_in               (rd),
    .e_irq_in                 (e_irq),
    .t_irq_in                 (t_irq),
    .s_irq_in                 (s_irq),
    .mie_in                   (mie),
    .meie_in                  (meie),
    .mtie_in                  (mtie),
    .msie_in                  (msie),
    .trap_taken_out           (trap_taken),
    .pc_src_out               (pc_src),
    .flush_out                (flush),
    .set_cause_out            (set_cause),
    .cause_out                (cause),
    .i_or_e_out               (i_or_e),
    .set_epc_out              (set_epc),
    .misaligned_exception_out (misal),
    .mie_clear_out            (mie_clr),
    .mie_set_out              (mie_set),
    .instret_inc_out          (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    illegal = 0; mis_ld = 0; mis_st = 0; mis_in = 0;
    opc = 0; f3 = 0; f7 = 0; rs1 = 0; rs2 = 0; rd = 0;
    e_irq = 0; t_irq = 0; s_irq = 0; mie = 0; meie = 0; mtie = 0; msie = 0;
  endtask

  task automatic set_ecall();
    opc = 5'b11100; f3 = 0; f7 = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic set_mret();
    opc = 5'b11100; f3 = 0; f7 = 7'b0011000; rs1 = 0; rs2 = 5'd2; rd = 0;
  endtask

  // Raise one set of conditions in OPERATING, expect trap, then check latched cause.
  task automatic trap_case(input string tag, input logic [3:0] ec, input logic ei, input logic em);
    #1;
    chk({tag, "_trap"}, {31'd0, trap_taken}, 1);
    tick();
    clr_in();
    chk({tag, "_pc"}, {30'd0, pc_src}, 2'b10);
    chk({tag, "_cause"}, {28'd0, cause}, {28'd0, ec});
    chk({tag, "_ie"}, {31'd0, i_or_e}, {31'd0, ei});
    chk({tag, "_mis"}, {31'd0, misal}, {31'd0, em});
    tick();
  endtask

  initial begin
    clr_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
    // 1: reset sequence
    chk("rst_pc", {30'd0, pc_src}, 2'b00);
    chk("rst_flush", {31'd0, flush}, 1);
    chk("rst_strobes", {27'd0, set_cause, set_epc, mie_clr, mie_set, instret}, 0);
    chk("rst_cause", {28'd0, cause}, 0);
    tick();
    chk("op_pc", {30'd0, pc_src}, 2'b11);
    chk("op_instret", {31'd0, instret}, 1);
    chk("op_flush", {31'd0, flush}, 0);

    // 2: illegal + misaligned load -> illegal wins
    illegal = 1; mis_ld = 1;
    #1;
    chk("ill_trap", {31'd0, trap_taken}, 1);
    chk("ill_instret", {31'd0, instret}, 0);
    tick();
    clr_in();
    chk("ill_pc", {30'd0, pc_src}, 2'b10);
    chk("ill_flush", {31'd0, flush}, 1);
    chk("ill_strobes", {29'd0, set_cause, set_epc, mie_clr}, 3'b111);
    chk("ill_cause", {28'd0, cause}, 2);
    chk("ill_ie", {31'd0, i_or_e}, 0);
    chk("ill_mis", {31'd0, misal}, 0);
    tick();
    chk("ill_back_pc", {30'd0, pc_src}, 2'b11);
    chk("ill_hold_cause", {28'd0, cause}, 2);
    chk("ill_hold_setc", {31'd0, set_cause}, 0);

    // 3: ecall then mret
    set_ecall();
    trap_case("ecall", 4'd11, 0, 0);
    set_mret();
    #1;
    chk("mret_trap", {31'd0, trap_taken}, 0);
    chk("mret_instret", {31'd0, instret}, 1);
    tick();
    clr_in();
    chk("mret_pc", {30'd0, pc_src}, 2'b01);
    chk("mret_flush", {31'd0, flush}, 1);
    chk("mret_mieset", {31'd0, mie_set}, 1);
    chk("mret_setc", {31'd0, set_cause}, 0);
    tick();
    chk("mret_back_pc", {30'd0, pc_src}, 2'b11);

    // 4: external beats timer; held irq ignored in TRAP_TAKEN; mie=0 masks all
    mie = 1; meie = 1; e_irq = 1; t_irq = 1; mtie = 1;
    #1;
    chk("ext_trap", {31'd0, trap_taken}, 1);
    tick();
    chk("ext_tt_notrap", {31'd0, trap_taken}, 0);
    chk("ext_cause", {28'd0, cause}, 11);
    chk("ext_ie", {31'd0, i_or_e}, 1);
    mie = 0;
    tick();
    chk("mask_trap", {31'd0, trap_taken}, 0);
    chk("mask_instret", {31'd0, instret}, 1);
    tick();
    chk("mask_stay_pc", {30'd0, pc_src}, 2'b11);
    clr_in();

    // 5: mret with pending software irq -> irq wins
    set_mret(); s_irq = 1; msie = 1; mie = 1;
    #1;
    chk("swmret_trap", {31'd0, trap_taken}, 1);
    tick();
    clr_in();
    chk("swmret_pc", {30'd0, pc_src}, 2'b10);
    chk("swmret_cause", {28'd0, cause}, 3);
    chk("swmret_ie", {31'd0, i_or_e}, 1);
    chk("swmret_mieset", {31'd0, mie_set}, 0);
    tick();

    // Remaining cause priorities
    mis_in = 1; mis_st = 1; illegal = 1;
    trap_case("misin", 4'd0, 0, 1);
    mis_st = 1; t_irq = 1; mtie = 1; mie = 1;
    trap_case("misst", 4'd6, 0, 1);
    opc = 5'b11100; rs2 = 5'd1; mis_ld = 1;
    trap_case("ebreak", 4'd3, 0, 0);
    mis_ld = 1; set_ecall();
    trap_case("misld", 4'd4, 0, 1);
    t_irq = 1; mtie = 1; mie = 1; s_irq = 1;
    trap_case("timer", 4'd7, 1, 0);
    // ecall with nonzero rd is not an ecall
    set_ecall(); rd = 5'd1;
    #1;
    chk("badecall_trap", {31'd0, trap_taken}, 0);
    tick();
    clr_in();

    // 6: reset during TRAP_TAKEN
    illegal = 1;
    tick();
    clr_in();
    chk("rsttt_pc", {30'd0, pc_src}, 2'b10);
    rst = 1;
    tick();
    chk("rsttt_pc0", {30'd0, pc_src}, 2'b00);
    chk("rsttt_flush", {31'd0, flush}, 1);
    chk("rsttt_cause", {28'd0, cause}, 0);
    chk("rsttt_mis", {31'd0, misal}, 0);
    rst = 0;
    tick();
    chk("rsttt_op_pc", {30'd0, pc_src}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
